ram4k_porta_arbiter: RTL and testbench
======================================

Name: ram4k_porta_arbiter

Overview:
- Shares port A of a 4K x 4 dual-port block RAM between two requesters, e.g. a PicoBlaze program-loader and a DMA/debug engine.
- Uses round-robin arbitration plus a bounded lock for read-modify-write sequences.
- Drives the RAM port-A enable, write-enable, address and data, and returns read data with one-cycle latency.
- Port B stays with its own owner; the arbiter only observes it, for the optional collision flag.

Parameters:
- ADDR_W, 12, RAM address width.
- DATA_W, 4, RAM data width.
- MAX_LOCK, 4, maximum extra consecutive grants one requester may hold via LOCK (must be >= 1).

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- REQ0/REQ1  in  1  access request, requester 0/1.
- WE0/WE1  in  1  write (1) / read (0) for the request.
- LOCK0/LOCK1  in  1  keep ownership after this grant.
- ADDR0/ADDR1  in  ADDR_W  access address.
- DI0/DI1  in  DATA_W  write data.
- GNT0/GNT1  out  1  request accepted this cycle.
- RDVLD0/RDVLD1  out  1  read data valid on DOx this cycle.
- DO0/DO1  out  DATA_W  read data, equal to RAM_DO.
- RAM_EN  out  1  port-A enable.
- RAM_WE  out  1  port-A write enable.
- RAM_ADDR  out  ADDR_W  port-A address.
- RAM_DI  out  DATA_W  port-A write data.
- RAM_DO  in  DATA_W  port-A read data.
- PB_EN  in  1  port-B enable, observed only.
- PB_WE  in  1  port-B write enable, observed only.
- PB_ADDR  in  ADDR_W  port-B address, observed only.
- COLL  out  1  port A/B collision flag.

Behaviour:
- Reset: one clock CLK; reset RST_N is asynchronous, active-low. While RST_N = 0: state=IDLE, PRI=0, lock counter=0, GNT0/1=0, RDVLD0/1=0, RAM_EN=0, RAM_WE=0, COLL=0.
- Grant is combinational in the request cycle. A request is accepted only when GNTx=1; an ungranted requester holds REQx and its fields stable until granted.
- FSM states: IDLE, OWN0, OWN1.
  - IDLE, one requester: that requester is granted.
  - IDLE, both requesting: requester PRI is granted.
  - IDLE, granted requester x has LOCKx=1: go to OWNx, counter=0. Otherwise stay in IDLE and set PRI = other requester.
  - OWNx: only x may be granted; the other requester is blocked.
  - OWNx, REQx=1: grant x and increment the counter.
  - OWNx exit: return to IDLE and set PRI = other requester when any of these holds: LOCKx=0 in a granted cycle; REQx=0 (no grant that cycle); the counter reaches MAX_LOCK (the forced-release grant is still performed).
  - Worst case, one requester holds port A for 1+MAX_LOCK consecutive cycles.
- RAM drive:
  - RAM_EN = GNT0|GNT1.
  - RAM_WE = RAM_EN & WE of the winner.
  - RAM_ADDR/RAM_DI = winner's ADDR/DI; all zeros when nothing is granted.
- Read latency: RDVLDx is registered as GNTx & ~WEx, so it is valid the cycle after the grant. DO0 and DO1 both mirror RAM_DO and are meaningful only while RDVLDx=1.
- Writes produce no RDVLD.
- Back-to-back: one access per cycle, no bubbles, including an alternating grant cycle to cycle.
- Reset mid-lock: returns to IDLE immediately and drops all outputs. An in-flight read's RDVLD is lost.

Optional Feature:
- Macro RAM4K_ARB_COLLISION_EN.
- Defined: COLL is registered and pulses 1 cycle after a cycle where RAM_EN & PB_EN & (RAM_ADDR==PB_ADDR) & (RAM_WE|PB_WE).
- Undefined: COLL is tied to 0 and the PB_* inputs are ignored. Ports remain present in both builds.

Decomposition:
- Package ram4k_arb_pkg: state enum (IDLE/OWN0/OWN1), requester-id type, default ADDR_W/DATA_W constants.
- Sub-module ram4k_arb_fsm: state, PRI, lock counter, GNT generation.
- Top level: request muxes, RDVLD registers, collision logic.

Test Plan:
- Reset with REQ0=1 held: GNT0=0 and RAM_EN=0 until RST_N rises; first grant on the first cycle after release.
- REQ0 write ADDR0=0x123 DI0=0xA; next cycle REQ0 read 0x123 -> RAM_WE=1 then 0; RDVLD0=1 with DO0=0xA the following cycle.
- REQ0 and REQ1 both held (non-lock) for 6 cycles -> grants alternate 0,1,0,1,0,1; RAM_ADDR tracks the winner each cycle.
- Requester 1 holds LOCK1 with REQ0 pending, MAX_LOCK=4 -> GNT1 for 5 consecutive cycles, then GNT0; PRI=0 after release.
- RST_N pulsed low while in OWN0 -> state IDLE, RDVLD0=0 immediately; next grant goes to requester 0 (PRI=0).
- With RAM4K_ARB_COLLISION_EN, port-A read 0x040 and PB_EN=1, PB_WE=1, PB_ADDR=0x040 -> COLL=1 one cycle later. With PB_ADDR=0x041 -> COLL=0. Without the macro -> COLL=0 always.

Source files
------------

// File: rtl/ram4k_arb_pkg.sv
// Shared types and defaults for the RAM4K port-A arbiter.
package ram4k_arb_pkg;

    localparam int unsigned DefAddrW = 12;
    localparam int unsigned DefDataW = 4;

    // IDLE: open round-robin; OWNx: requester x holds port A under LOCK
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } arb_state_e;

    // Requester id: 0 or 1
    typedef logic req_id_t;

    function automatic req_id_t other_req(input req_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/ram4k_arb_fsm.sv
// Arbitration core: owner state, round-robin pointer, lock counter and grants.
module ram4k_arb_fsm
    import ram4k_arb_pkg::*;
#(
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic lock0,
    input  logic lock1,
    output logic gnt0,
    output logic gnt1
);

    localparam int unsigned CntW = $clog2(MAX_LOCK + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(MAX_LOCK - 1);

    arb_state_e      state_q;
    req_id_t         pri_q;
    logic [CntW-1:0] cnt_q;

    logic    win_valid;
    req_id_t win_id;
    logic    lock_win;

    // Pick this cycle's winner; in OWNx only the owner can win.
    always_comb begin
        win_valid = 1'b0;
        win_id    = 1'b0;
        unique case (state_q)
            StOwn0: begin
                win_valid = req0;
                win_id    = 1'b0;
            end
            StOwn1: begin
                win_valid = req1;
                win_id    = 1'b1;
            end
            default: begin
                if (req0 && req1) begin
                    win_valid = 1'b1;
                    win_id    = pri_q;
                end else if (req0) begin
                    win_valid = 1'b1;
                    win_id    = 1'b0;
                end else if (req1) begin
                    win_valid = 1'b1;
                    win_id    = 1'b1;
                end
            end
        endcase
    end

    assign lock_win = win_id ? lock1 : lock0;
    // Grants are forced low while reset is asserted, not just after the next edge.
    assign gnt0 = rst_n & win_valid & ~win_id;
    assign gnt1 = rst_n & win_valid & win_id;

    // Ownership, round-robin pointer and lock-length bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pri_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StOwn0, StOwn1: begin
                    // Release on dropped request, dropped lock, or the forced-release grant.
                    if (!win_valid || !lock_win || cnt_q == CntLast) begin
                        state_q <= StIdle;
                        pri_q   <= other_req(win_id);
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    if (win_valid) begin
                        if (lock_win) begin
                            state_q <= win_id ? StOwn1 : StOwn0;
                            cnt_q   <= '0;
                        end else begin
                            pri_q <= other_req(win_id);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/ram4k_porta_arbiter.sv
// Two-requester arbiter for port A of a 4K x 4 dual-port RAM.
// Optional port A/B collision flag enabled by defining RAM4K_ARB_COLLISION_EN.
module ram4k_porta_arbiter
    import ram4k_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] di0,
    input  logic [DATA_W-1:0] di1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rdvld0,
    output logic              rdvld1,
    output logic [DATA_W-1:0] do0,
    output logic [DATA_W-1:0] do1,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do,
    input  logic              pb_en,
    input  logic              pb_we,
    input  logic [ADDR_W-1:0] pb_addr,
    output logic              coll
);

    logic rdvld0_q;
    logic rdvld1_q;

    ram4k_arb_fsm #(
        .MAX_LOCK(MAX_LOCK)
    ) u_fsm (
        .clk  (clk),
        .rst_n(rst_n),
        .req0 (req0),
        .req1 (req1),
        .lock0(lock0),
        .lock1(lock1),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    assign ram_en = gnt0 | gnt1;

    // Route the winner's fields to port A; an idle port is driven to zero.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_di   = '0;
        if (gnt0) begin
            ram_we   = we0;
            ram_addr = addr0;
            ram_di   = di0;
        end else if (gnt1) begin
            ram_we   = we1;
            ram_addr = addr1;
            ram_di   = di1;
        end
    end

    // Read-valid follows a granted read by one cycle, matching RAM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdvld0_q <= 1'b0;
            rdvld1_q <= 1'b0;
        end else begin
            rdvld0_q <= gnt0 & ~we0;
            rdvld1_q <= gnt1 & ~we1;
        end
    end

    assign rdvld0 = rdvld0_q;
    assign rdvld1 = rdvld1_q;
    assign do0    = ram_do;
    assign do1    = ram_do;

`ifdef RAM4K_ARB_COLLISION_EN
    logic coll_hit;
    logic coll_q;

    assign coll_hit = ram_en & pb_en & (ram_addr == pb_addr) & (ram_we | pb_we);

    // Flag same-address A/B accesses where at least one side writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= coll_hit;
        end
    end

    assign coll = coll_q;
`else
    logic unused_pb;
    assign unused_pb = ^{pb_en, pb_we, pb_addr};
    assign coll      = 1'b0;
`endif

endmodule

// File: tb/tb_ram4k_porta_arbiter.sv
// Self-checking bench for ram4k_porta_arbiter: directed cases plus randomized traffic
// compared every cycle against a behavioural model of the arbitration rules.
module tb_ram4k_porta_arbiter;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 4;
    localparam int ML = 4;
`ifdef RAM4K_ARB_COLLISION_EN
    localparam bit CollOn = 1'b1;
`else
    localparam bit CollOn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic          lock0 = 1'b0, lock1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] di0 = '0, di1 = '0;
    logic          gnt0, gnt1, rdvld0, rdvld1;
    logic [DW-1:0] do0, do1;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_do;
    logic          pb_en = 1'b0, pb_we = 1'b0;
    logic [AW-1:0] pb_addr = '0;
    logic          coll;

    int checks = 0;
    int errors = 0;

    // Model grants for the current cycle, used by the driver's hold rule.
    logic m_gnt0 = 1'b0;
    logic m_gnt1 = 1'b0;

    logic [DW-1:0] ram  [4096];
    logic [DW-1:0] mmem [4096];

    ram4k_porta_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .MAX_LOCK(ML)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .req1    (req1),
        .we0     (we0),
        .we1     (we1),
        .lock0   (lock0),
        .lock1   (lock1),
        .addr0   (addr0),
        .addr1   (addr1),
        .di0     (di0),
        .di1     (di1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .rdvld0  (rdvld0),
        .rdvld1  (rdvld1),
        .do0     (do0),
        .do1     (do1),
        .ram_en  (ram_en),
        .ram_we  (ram_we),
        .ram_addr(ram_addr),
        .ram_di  (ram_di),
        .ram_do  (ram_do),
        .pb_en   (pb_en),
        .pb_we   (pb_we),
        .pb_addr (pb_addr),
        .coll    (coll)
    );

    initial forever #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 4095));
        return AW'($urandom_range(0, 15));
    endfunction

    // Behavioural RAM behind port A: one-cycle read latency.
    initial begin : ram_model
        for (int i = 0; i < 4096; i++) ram[i] <= '0;
        ram_do <= '0;
        forever begin
            @(posedge clk);
            if (ram_en) begin
                if (ram_we) ram[ram_addr] <= ram_di;
                else        ram_do <= ram[ram_addr];
            end
        end
    end

    // Reference model and per-cycle comparison.
    initial begin : compare
        int owner;
        int pri;
        int left;
        int w;
        logic rd0_e, rd1_e, coll_e, en, we, lk;
        logic [DW-1:0] rdata;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int i = 0; i < 4096; i++) mmem[i] = '0;
        owner = -1; pri = 0; left = 0;
        rd0_e = 1'b0; rd1_e = 1'b0; coll_e = 1'b0; rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                owner = -1; pri = 0; left = 0;
                rd0_e = 1'b0; rd1_e = 1'b0; coll_e = 1'b0;
                m_gnt0 = 1'b0; m_gnt1 = 1'b0;
                chk("rst_gnt", 32'({gnt1, gnt0}), 32'(0));
                chk("rst_port", 32'({ram_en, ram_we, ram_addr, ram_di}), 32'(0));
                chk("rst_rdvld", 32'({rdvld1, rdvld0}), 32'(0));
                chk("rst_coll", 32'(coll), 32'(0));
            end else begin
                if (owner >= 0) w = ((owner == 0) ? req0 : req1) ? owner : -1;
                else if (req0 && req1) w = pri;
                else if (req0) w = 0;
                else if (req1) w = 1;
                else w = -1;
                m_gnt0 = (w == 0);
                m_gnt1 = (w == 1);
                en = (w >= 0);
                we = (w == 0) ? we0 : (w == 1) ? we1 : 1'b0;
                a  = (w == 0) ? addr0 : (w == 1) ? addr1 : '0;
                d  = (w == 0) ? di0 : (w == 1) ? di1 : '0;
                lk = (w == 0) ? lock0 : (w == 1) ? lock1 : 1'b0;
                chk("gnt", 32'({gnt1, gnt0}), 32'({m_gnt1, m_gnt0}));
                chk("ram_en", 32'(ram_en), 32'(en));
                chk("ram_we", 32'(ram_we), 32'(we));
                chk("ram_addr", 32'(ram_addr), 32'(a));
                chk("ram_di", 32'(ram_di), 32'(d));
                chk("rdvld", 32'({rdvld1, rdvld0}), 32'({rd1_e, rd0_e}));
                if (rd0_e) chk("do0", 32'(do0), 32'(rdata));
                if (rd1_e) chk("do1", 32'(do1), 32'(rdata));
                chk("coll", 32'(coll), 32'(coll_e));
                // Advance the model by one clock.
                if (en) begin
                    if (we) mmem[a] = d;
                    else    rdata = mmem[a];
                end
                rd0_e  = m_gnt0 && !we0;
                rd1_e  = m_gnt1 && !we1;
                coll_e = CollOn && en && pb_en && (a == pb_addr) && (we || pb_we);
                if (owner >= 0) begin
                    if (w < 0) begin
                        pri = 1 - owner; owner = -1;
                    end else begin
                        left--;
                        if (!lk || left == 0) begin
                            pri = 1 - owner; owner = -1;
                        end
                    end
                end else if (w >= 0) begin
                    if (lk) begin
                        owner = w; left = ML;
                    end else begin
                        pri = 1 - w;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : drive
        // Reset held with a pending write from requester 0.
        req0 = 1'b1; we0 = 1'b1; addr0 = 12'h123; di0 = 4'hA;
        repeat (2) begin
            tick(); #5;
            chk("d_rst_gnt0", 32'(gnt0), 32'(0));
            chk("d_rst_en", 32'(ram_en), 32'(0));
        end
        tick(); rst_n = 1'b1; #5;
        chk("d_first_gnt0", 32'(gnt0), 32'(1));
        chk("d_wr_we", 32'(ram_we), 32'(1));
        chk("d_wr_addr", 32'(ram_addr), 32'h123);
        chk("d_wr_di", 32'(ram_di), 32'hA);
        tick(); we0 = 1'b0; #5;
        chk("d_rd_gnt0", 32'(gnt0), 32'(1));
        chk("d_rd_we", 32'(ram_we), 32'(0));
        tick(); req0 = 1'b0; #5;
        chk("d_rd_vld0", 32'(rdvld0), 32'(1));
        chk("d_rd_do0", 32'(do0), 32'hA);

        // Both requesting without lock; PRI points at 1 after two grants to 0.
        tick();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 12'h0A0; addr1 = 12'h0B1;
        for (int i = 0; i < 6; i++) begin
            #5;
            chk("d_alt_gnt", 32'({gnt1, gnt0}), (i % 2 == 0) ? 32'h2 : 32'h1);
            chk("d_alt_addr", 32'(ram_addr), (i % 2 == 0) ? 32'h0B1 : 32'h0A0);
            tick();
        end

        // Requester 1 locks with requester 0 pending: 1 + MAX_LOCK grants, then 0.
        lock1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #5;
            chk("d_lock_gnt1", 32'({gnt1, gnt0}), 32'h2);
            tick();
        end
        lock1 = 1'b0; #5;
        chk("d_rel_gnt0", 32'({gnt1, gnt0}), 32'h1);
        tick(); #5;
        chk("d_rel_gnt1", 32'({gnt1, gnt0}), 32'h2);

        // Enter OWN0 with reads, then reset while a read is in flight.
        tick();
        req1 = 1'b0; lock0 = 1'b1; addr0 = 12'h055; #5;
        chk("d_own_gnt0", 32'(gnt0), 32'(1));
        tick(); #5;
        chk("d_own_gnt0b", 32'(gnt0), 32'(1));
        tick();
        rst_n = 1'b0; #1;
        chk("d_mid_rdvld0", 32'(rdvld0), 32'(0));
        chk("d_mid_gnt0", 32'(gnt0), 32'(0));
        tick();
        rst_n = 1'b1; lock0 = 1'b0; req1 = 1'b1; #5;
        chk("d_post_rst_gnt", 32'({gnt1, gnt0}), 32'h1);

        // Collision: A read vs B write at the same address, then a different address.
        tick();
        req1 = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 12'h040;
        pb_en = 1'b1; pb_we = 1'b1; pb_addr = 12'h040;
        tick();
        req0 = 1'b0; pb_en = 1'b0; #5;
        chk("d_coll_hit", 32'(coll), 32'(CollOn));
        tick();
        req0 = 1'b1; pb_en = 1'b1; pb_addr = 12'h041;
        tick();
        req0 = 1'b0; pb_en = 1'b0; #5;
        chk("d_coll_miss", 32'(coll), 32'(0));

        // Randomized traffic; an ungranted requester holds its request stable.
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst_n = ($urandom_range(0, 299) != 0);
            if (!(req0 && !m_gnt0)) begin
                req0  = ($urandom_range(0, 9) < 6);
                we0   = 1'($urandom_range(0, 1));
                lock0 = ($urandom_range(0, 9) < 3);
                addr0 = rnd_addr();
                di0   = DW'($urandom);
            end
            if (!(req1 && !m_gnt1)) begin
                req1  = ($urandom_range(0, 9) < 6);
                we1   = 1'($urandom_range(0, 1));
                lock1 = ($urandom_range(0, 9) < 3);
                addr1 = rnd_addr();
                di1   = DW'($urandom);
            end
            pb_en   = 1'($urandom_range(0, 1));
            pb_we   = 1'($urandom_range(0, 1));
            pb_addr = ($urandom_range(0, 1) != 0) ? (($urandom_range(0, 1) != 0) ? addr0 : addr1)
                                                  : rnd_addr();
        end
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
